// File: rtl/cpu_types_pkg.sv
// Shared CPU types: register indices, pipeline-control FSM states and
// the width of the stall counter.
package cpu_types_pkg;

  typedef logic [4:0] regbits_t;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    DWAIT = 2'd1,
    HALT  = 2'd2
  } pctrl_state_t;

  localparam int STALL_CNT_W = 16;

endpackage

// File: rtl/pipeline_ctrl_if.sv
// Hazard inputs and pipeline-register controls exchanged between the
// datapath (master) and the pipeline controller (slave).
interface pipeline_ctrl_if;
  import cpu_types_pkg::*;

  logic                   ihit;
  logic                   dhit;
  logic                   mem_dREN;
  logic                   mem_dWEN;
  logic                   ex_dREN;
  regbits_t               ex_wsel;
  regbits_t               id_rsel1;
  regbits_t               id_rsel2;
  logic                   id_uses_rt;
  logic                   ex_branch_taken;
  logic                   id_jump;
  logic                   mem_halt;

  logic                   pc_W;
  logic                   ifid_W;
  logic                   ifid_RST;
  logic                   idex_W;
  logic                   idex_RST;
  logic                   exmem_W;
  logic                   exmem_RST;
  logic                   memwb_W;
  logic                   halted;
  logic [STALL_CNT_W-1:0] stall_cnt;

  modport master (
    output ihit, dhit, mem_dREN, mem_dWEN, ex_dREN, ex_wsel, id_rsel1,
           id_rsel2, id_uses_rt, ex_branch_taken, id_jump, mem_halt,
    input  pc_W, ifid_W, ifid_RST, idex_W, idex_RST, exmem_W, exmem_RST,
           memwb_W, halted, stall_cnt
  );

  modport slave (
    input  ihit, dhit, mem_dREN, mem_dWEN, ex_dREN, ex_wsel, id_rsel1,
           id_rsel2, id_uses_rt, ex_branch_taken, id_jump, mem_halt,
    output pc_W, ifid_W, ifid_RST, idex_W, idex_RST, exmem_W, exmem_RST,
           memwb_W, halted, stall_cnt
  );

endinterface

// File: rtl/sat_counter.sv
// Up-counter that sticks at its all-ones value instead of wrapping,
// with a synchronous active-high clear.
module sat_counter #(
  parameter int WIDTH = 16
) (
  input  logic             CLK,
  input  logic             clr,
  input  logic             en,
  output logic [WIDTH-1:0] count
);

  always_ff @(posedge CLK) begin
    if (clr)
      count <= '0;
    else if (en && (count != {WIDTH{1'b1}}))
      count <= count + WIDTH'(1);
  end

endmodule

// File: rtl/pipeline_ctrl.sv
// Hazard and stall controller for the five-stage pipeline: decides every
// cycle which pipeline registers load, flush or hold.
module pipeline_ctrl
  import cpu_types_pkg::*;
(
  input  logic            CLK,
  input  logic            RST,
  pipeline_ctrl_if.slave  ctl
);

  pctrl_state_t           state;
  pctrl_state_t           next_state;
  logic                   ihit_seen;
  logic                   ihit_e;
  logic                   dwait;
  logic                   lu;
  logic                   pc_w;
  logic                   ifid_w;
  logic                   ifid_rst;
  logic                   idex_w;
  logic                   idex_rst;
  logic                   exmem_w;
  logic                   exmem_rst;
  logic                   memwb_w;
  logic [STALL_CNT_W-1:0] stall_count;

  assign ihit_e = ctl.ihit | ihit_seen;
  assign dwait  = (ctl.mem_dREN | ctl.mem_dWEN) & ~ctl.dhit;
  assign lu     = ctl.ex_dREN & (ctl.ex_wsel != '0) &
                  ((ctl.ex_wsel == ctl.id_rsel1) |
                   (ctl.id_uses_rt & (ctl.ex_wsel == ctl.id_rsel2)));

  always_ff @(posedge CLK) begin
    if (RST)
      state <= RUN;
    else
      state <= next_state;
  end

  // A fetch that completes while the PC is held must survive until the PC advances.
  always_ff @(posedge CLK) begin
    if (RST)
      ihit_seen <= 1'b0;
    else if (pc_w)
      ihit_seen <= 1'b0;
    else if (ctl.ihit)
      ihit_seen <= 1'b1;
  end

  always_comb begin
    next_state = state;
    case (state)
      RUN, DWAIT: begin
        if (ctl.mem_halt)
          next_state = HALT;
        else if (dwait)
          next_state = DWAIT;
        else
          next_state = RUN;
      end
      HALT:    next_state = HALT;
      default: next_state = RUN;
    endcase
  end

  always_comb begin
    pc_w      = 1'b0;
    ifid_w    = 1'b0;
    ifid_rst  = 1'b0;
    idex_w    = 1'b0;
    idex_rst  = 1'b0;
    exmem_w   = 1'b0;
    exmem_rst = 1'b0;
    memwb_w   = 1'b0;
    if (state != HALT) begin
      if (ctl.mem_halt) begin
        exmem_w = 1'b1;
        memwb_w = 1'b1;
      end else if (dwait) begin
        // Full freeze: everything keeps its value until memory answers.
      end else if (ctl.ex_branch_taken) begin
        pc_w     = 1'b1;
        ifid_rst = 1'b1;
        idex_rst = 1'b1;
        exmem_w  = 1'b1;
        memwb_w  = 1'b1;
      end else if (lu) begin
        idex_rst = 1'b1;
        exmem_w  = 1'b1;
        memwb_w  = 1'b1;
      end else if (ctl.id_jump && ihit_e) begin
        pc_w     = 1'b1;
        ifid_rst = 1'b1;
        idex_w   = 1'b1;
        exmem_w  = 1'b1;
        memwb_w  = 1'b1;
      end else if (ihit_e) begin
        pc_w    = 1'b1;
        ifid_w  = 1'b1;
        idex_w  = 1'b1;
        exmem_w = 1'b1;
        memwb_w = 1'b1;
      end else begin
        ifid_rst = 1'b1;
        idex_w   = 1'b1;
        exmem_w  = 1'b1;
        memwb_w  = 1'b1;
      end
    end
  end

  sat_counter #(
    .WIDTH (STALL_CNT_W)
  ) u_stall_cnt (
    .CLK   (CLK),
    .clr   (RST),
    .en    ((state != HALT) & ~pc_w),
    .count (stall_count)
  );

  assign ctl.pc_W      = pc_w;
  assign ctl.ifid_W    = ifid_w;
  assign ctl.ifid_RST  = ifid_rst;
  assign ctl.idex_W    = idex_w;
  assign ctl.idex_RST  = idex_rst;
  assign ctl.exmem_W   = exmem_w;
  assign ctl.exmem_RST = exmem_rst;
  assign ctl.memwb_W   = memwb_w;
  assign ctl.halted    = (state == HALT);
  assign ctl.stall_cnt = stall_count;

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Bench for pipeline_ctrl: a rule-table model checked every cycle, plus
// directed scenarios with hand-computed expectations.
module tb_pipeline_ctrl;
  import cpu_types_pkg::*;

  typedef struct packed {
    logic     rst;
    logic     ihit;
    logic     dhit;
    logic     mem_dREN;
    logic     mem_dWEN;
    logic     ex_dREN;
    regbits_t ex_wsel;
    regbits_t id_rsel1;
    regbits_t id_rsel2;
    logic     id_uses_rt;
    logic     ex_branch_taken;
    logic     id_jump;
    logic     mem_halt;
  } stim_t;

  // Control vector order: pc_W ifid_W ifid_RST idex_W idex_RST exmem_W exmem_RST memwb_W
  localparam logic [7:0] C_HALTING = 8'h05;
  localparam logic [7:0] C_FREEZE  = 8'h00;
  localparam logic [7:0] C_BRANCH  = 8'hAD;
  localparam logic [7:0] C_LOADUSE = 8'h0D;
  localparam logic [7:0] C_JUMP    = 8'hB5;
  localparam logic [7:0] C_ADVANCE = 8'hD5;
  localparam logic [7:0] C_BUBBLE  = 8'h35;

  logic CLK = 1'b0;
  logic RST;
  pipeline_ctrl_if bus ();

  pipeline_ctrl dut (
    .CLK (CLK),
    .RST (RST),
    .ctl (bus)
  );

  always #5 CLK = ~CLK;

  int    tests_run    = 0;
  int    tests_failed = 0;
  bit    model_valid  = 1'b0;
  bit    m_halted;
  bit    m_seen;
  int    m_cnt;
  stim_t cur;

  function automatic logic [7:0] expectedCtrl(stim_t s, bit halted, bit seen);
    bit hit;
    bit dw;
    bit luse;
    hit  = s.ihit | seen;
    dw   = (s.mem_dREN | s.mem_dWEN) & ~s.dhit;
    luse = s.ex_dREN && (s.ex_wsel != 0) &&
           ((s.ex_wsel == s.id_rsel1) || (s.id_uses_rt && (s.ex_wsel == s.id_rsel2)));
    if (halted)            return C_FREEZE;
    if (s.mem_halt)        return C_HALTING;
    if (dw)                return C_FREEZE;
    if (s.ex_branch_taken) return C_BRANCH;
    if (luse)              return C_LOADUSE;
    if (s.id_jump && hit)  return C_JUMP;
    if (hit)               return C_ADVANCE;
    return C_BUBBLE;
  endfunction

  function automatic logic [7:0] dutCtrl();
    return {bus.pc_W, bus.ifid_W, bus.ifid_RST, bus.idex_W,
            bus.idex_RST, bus.exmem_W, bus.exmem_RST, bus.memwb_W};
  endfunction

  task automatic report(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s at %0t: got %h, expected %h", name, $time, act, exp);
    end
  endtask

  // Compare against the model, then advance the model across the coming edge.
  task automatic modelStep();
    logic [7:0] exp;
    exp = expectedCtrl(cur, m_halted, m_seen);
    if (model_valid) begin
      report("model_ctrl", 32'(dutCtrl()), 32'(exp));
      report("model_halted", 32'(bus.halted), 32'(m_halted));
      report("model_stall_cnt", 32'(bus.stall_cnt), 32'(m_cnt));
    end
    if (cur.rst) begin
      model_valid = 1'b1;
      m_halted    = 1'b0;
      m_seen      = 1'b0;
      m_cnt       = 0;
    end else if (model_valid) begin
      if (!m_halted && !exp[7] && m_cnt < 65535)
        m_cnt++;
      if (exp[7])
        m_seen = 1'b0;
      else if (cur.ihit)
        m_seen = 1'b1;
      if (!m_halted && cur.mem_halt)
        m_halted = 1'b1;
    end
  endtask

  task automatic applyStimulus(input stim_t s);
    @(posedge CLK);
    #1;
    cur                 = s;
    RST                 = s.rst;
    bus.ihit            = s.ihit;
    bus.dhit            = s.dhit;
    bus.mem_dREN        = s.mem_dREN;
    bus.mem_dWEN        = s.mem_dWEN;
    bus.ex_dREN         = s.ex_dREN;
    bus.ex_wsel         = s.ex_wsel;
    bus.id_rsel1        = s.id_rsel1;
    bus.id_rsel2        = s.id_rsel2;
    bus.id_uses_rt      = s.id_uses_rt;
    bus.ex_branch_taken = s.ex_branch_taken;
    bus.id_jump         = s.id_jump;
    bus.mem_halt        = s.mem_halt;
    @(negedge CLK);
    modelStep();
  endtask

  task automatic checkOutput(input string name, input logic [7:0] ctrl,
                             input logic halted, input logic [15:0] cnt);
    report({name, "_ctrl"}, 32'(dutCtrl()), 32'(ctrl));
    report({name, "_halted"}, 32'(bus.halted), 32'(halted));
    report({name, "_stall_cnt"}, 32'(bus.stall_cnt), 32'(cnt));
  endtask

  task automatic doReset();
    stim_t s;
    s     = '0;
    s.rst = 1'b1;
    applyStimulus(s);
  endtask

  initial begin
    stim_t s;
    cur = '0;
    RST = 1'b0;
    bus.ihit = 1'b0; bus.dhit = 1'b0; bus.mem_dREN = 1'b0; bus.mem_dWEN = 1'b0;
    bus.ex_dREN = 1'b0; bus.ex_wsel = '0; bus.id_rsel1 = '0; bus.id_rsel2 = '0;
    bus.id_uses_rt = 1'b0; bus.ex_branch_taken = 1'b0; bus.id_jump = 1'b0;
    bus.mem_halt = 1'b0;

    // Load-use, then no hazard against r0, then branch beating load-use.
    doReset();
    s = '0; s.ihit = 1'b1; s.ex_dREN = 1'b1; s.ex_wsel = 5'd5; s.id_rsel1 = 5'd5;
    applyStimulus(s);
    checkOutput("loaduse", C_LOADUSE, 1'b0, 16'd0);
    s.ex_wsel = 5'd0; s.id_rsel1 = 5'd0;
    applyStimulus(s);
    checkOutput("loaduse_r0", C_ADVANCE, 1'b0, 16'd1);
    s.ex_wsel = 5'd5; s.id_rsel1 = 5'd5; s.ex_branch_taken = 1'b1;
    applyStimulus(s);
    checkOutput("branch_over_lu", C_BRANCH, 1'b0, 16'd1);

    // Data wait with an ihit arriving mid-freeze.
    doReset();
    s = '0; s.mem_dREN = 1'b1;
    applyStimulus(s);
    checkOutput("dwait_c1", C_FREEZE, 1'b0, 16'd0);
    s.ihit = 1'b1;
    applyStimulus(s);
    checkOutput("dwait_c2", C_FREEZE, 1'b0, 16'd1);
    s.ihit = 1'b0;
    applyStimulus(s);
    checkOutput("dwait_c3", C_FREEZE, 1'b0, 16'd2);
    s.dhit = 1'b1;
    applyStimulus(s);
    checkOutput("dwait_release", C_ADVANCE, 1'b0, 16'd3);
    s = '0;
    applyStimulus(s);
    checkOutput("dwait_hit_consumed", C_BUBBLE, 1'b0, 16'd3);

    // Jump waiting for its fetch.
    doReset();
    s = '0; s.id_jump = 1'b1;
    applyStimulus(s);
    checkOutput("jump_wait1", C_BUBBLE, 1'b0, 16'd0);
    applyStimulus(s);
    checkOutput("jump_wait2", C_BUBBLE, 1'b0, 16'd1);
    s.ihit = 1'b1;
    applyStimulus(s);
    checkOutput("jump_taken", C_JUMP, 1'b0, 16'd2);

    // Halt, hold for ten cycles, leave only through reset.
    doReset();
    s = '0; s.ihit = 1'b1; s.mem_halt = 1'b1;
    applyStimulus(s);
    checkOutput("halt_enter", C_HALTING, 1'b0, 16'd0);
    for (int i = 0; i < 10; i++) begin
      s = '0; s.ihit = 1'b1; s.ex_branch_taken = (i % 2 == 0);
      applyStimulus(s);
      checkOutput("halt_hold", C_FREEZE, 1'b1, 16'd1);
    end
    doReset();
    checkOutput("halt_rst_cycle", C_FREEZE, 1'b1, 16'd1);
    s = '0; s.ihit = 1'b1;
    applyStimulus(s);
    checkOutput("halt_exit", C_ADVANCE, 1'b0, 16'd0);

    // Stall counter saturation.
    doReset();
    s = '0;
    for (int i = 0; i < 70000; i++)
      applyStimulus(s);
    checkOutput("sat_reach", C_BUBBLE, 1'b0, 16'hFFFF);
    applyStimulus(s);
    checkOutput("sat_hold", C_BUBBLE, 1'b0, 16'hFFFF);

    // Randomised traffic against the model.
    doReset();
    for (int i = 0; i < 2000; i++) begin
      s                 = '0;
      s.rst             = ($urandom_range(0, 59) == 0);
      s.ihit            = ($urandom_range(0, 1) == 1);
      s.dhit            = ($urandom_range(0, 9) < 6);
      s.mem_dREN        = ($urandom_range(0, 9) < 2);
      s.mem_dWEN        = ($urandom_range(0, 9) == 0);
      s.ex_dREN         = ($urandom_range(0, 9) < 3);
      s.ex_wsel         = regbits_t'($urandom_range(0, 3));
      s.id_rsel1        = regbits_t'($urandom_range(0, 3));
      s.id_rsel2        = regbits_t'($urandom_range(0, 3));
      s.id_uses_rt      = ($urandom_range(0, 1) == 1);
      s.ex_branch_taken = ($urandom_range(0, 9) == 0);
      s.id_jump         = ($urandom_range(0, 9) == 0);
      s.mem_halt        = ($urandom_range(0, 49) == 0);
      applyStimulus(s);
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
